// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bus between the 5-stage pipeline datapath (master) and hazard_stall_ctrl (slave).
// The master drives the hazard-detection inputs; the slave drives the stall, flush and bubble controls.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] IFID_RsAddr_i;
  logic [REG_AW-1:0] IFID_RtAddr_i;
  logic              IFID_UsesRt_i;
  logic              IDEX_MemRead_i;
  logic [REG_AW-1:0] IDEX_RtAddr_i;
  logic              EXMEM_MemReq_i;
  logic              dmem_ready_i;
  logic              branch_taken_i;
  logic              PC_Write_o;
  logic              IFID_Write_o;
  logic              IFID_Flush_o;
  logic              IDEX_Bubble_o;
  logic              Stage_Hold_o;
  logic              MEMWB_Bubble_o;
  logic              mem_err_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output IFID_RsAddr_i, IFID_RtAddr_i, IFID_UsesRt_i, IDEX_MemRead_i, IDEX_RtAddr_i,
           EXMEM_MemReq_i, dmem_ready_i, branch_taken_i,
    input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Stage_Hold_o,
           MEMWB_Bubble_o, mem_err_o, stall_cnt_o
  );
  modport slave (
    input  IFID_RsAddr_i, IFID_RtAddr_i, IFID_UsesRt_i, IDEX_MemRead_i, IDEX_RtAddr_i,
           EXMEM_MemReq_i, dmem_ready_i, branch_taken_i,
    output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Stage_Hold_o,
           MEMWB_Bubble_o, mem_err_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use stalls, memory-wait freeze, deferred branch flush, sticky timeout.
// Optional macro STALL_PERF_EN adds a saturating stall-cycle counter on stall_cnt_o.
module hazard_stall_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hazard_stall_ctrl_if.slave      bus
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FREEZE, ERROR} st_t;

  st_t            st, st_nx;
  logic [WCW-1:0] wait_cnt, wait_cnt_nx;
  logic           flush_pend, flush_pend_nx;
  logic [31:0]    wait_inc;
  logic [REG_AW-1:0] ld_rt;
  logic frz, lu, fl;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, stage_hold, memwb_bubble, mem_err;

  assign ld_rt    = bus.IDEX_RtAddr_i;
  assign frz      = bus.EXMEM_MemReq_i & ~bus.dmem_ready_i;
  assign lu       = bus.IDEX_MemRead_i & (ld_rt != '0) &
                    ((ld_rt == bus.IFID_RsAddr_i) |
                     (bus.IFID_UsesRt_i & (ld_rt == bus.IFID_RtAddr_i)));
  assign fl       = bus.branch_taken_i | flush_pend;
  assign wait_inc = 32'(wait_cnt) + 32'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st         <= RUN;
      wait_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      st         <= st_nx;
      wait_cnt   <= wait_cnt_nx;
      flush_pend <= flush_pend_nx;
    end
  end

  always_comb begin
    st_nx         = st;
    wait_cnt_nx   = wait_cnt;
    flush_pend_nx = flush_pend;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    stage_hold    = 1'b0;
    memwb_bubble  = 1'b0;
    mem_err       = 1'b0;
    if (!rst_i) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      stage_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (st == ERROR || frz) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      stage_hold   = 1'b1;
      memwb_bubble = 1'b1;
      mem_err      = (st == ERROR);
      if (st != ERROR) begin
        // A branch resolved while frozen is remembered and applied on the exit cycle
        flush_pend_nx = flush_pend | bus.branch_taken_i;
        wait_cnt_nx   = wait_inc[WCW-1:0];
        st_nx         = (wait_inc >= 32'(MEM_TIMEOUT)) ? ERROR : FREEZE;
      end
    end else begin
      st_nx       = RUN;
      wait_cnt_nx = '0;
      if (fl) begin
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        flush_pend_nx = 1'b0;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign bus.PC_Write_o     = pc_write;
  assign bus.IFID_Write_o   = ifid_write;
  assign bus.IFID_Flush_o   = ifid_flush;
  assign bus.IDEX_Bubble_o  = idex_bubble;
  assign bus.Stage_Hold_o   = stage_hold;
  assign bus.MEMWB_Bubble_o = memwb_bubble;
  assign bus.mem_err_o      = mem_err;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      stall_cnt <= '0;
    else if (!pc_write && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.stall_cnt_o = stall_cnt;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  assign bus.stall_cnt_o = CNT_ZERO;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, stall-counter saturation, then random traffic vs a model.
module tb_hazard_stall_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus();
  hazard_stall_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] idex_rt;
    logic       memreq;
    logic       ready;
    logic       br;
  } in_t;

  // expected flag order: pc_write, ifid_write, flush, idex_bubble, hold, memwb_bubble, err
  typedef struct packed {
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] O_RST = 7'b0001110;
  localparam logic [6:0] O_NRM = 7'b1100000;
  localparam logic [6:0] O_LU  = 7'b0001000;
  localparam logic [6:0] O_FRZ = 7'b0000110;
  localparam logic [6:0] O_FL  = 7'b1111000;
  localparam logic [6:0] O_ERR = 7'b0000111;

  int checks = 0;
  int errors = 0;

  // reference model state: error latch, cycles waited, deferred flush, stall total
  bit m_err;
  int m_waited;
  bit m_pend;
  int m_stalls;

  function automatic in_t mk(logic r, int rs, int rt, logic u, logic mr, int irt,
                             logic req, logic rdy, logic br);
    in_t v;
    v.rst = r; v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u; v.memread = mr;
    v.idex_rt = 5'(irt); v.memreq = req; v.ready = rdy; v.br = br;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Derives expected flags for this cycle and advances the model past the coming edge.
  task automatic model(input in_t v, output logic [6:0] o);
    bit hazard, stalled;
    if (!v.rst) begin
      o = O_RST;
      m_err = 0; m_waited = 0; m_pend = 0; m_stalls = 0;
      return;
    end
    stalled = 0;
    if (m_err) begin
      o = O_ERR; stalled = 1;
    end else if (v.memreq && !v.ready) begin
      o = O_FRZ; stalled = 1;
      m_pend = m_pend || v.br;
      m_waited = m_waited + 1;
      if (m_waited >= TO) m_err = 1;
    end else begin
      m_waited = 0;
      hazard = v.memread && v.idex_rt != 0 &&
               (v.idex_rt == v.rs || (v.uses_rt && v.idex_rt == v.rt));
      if (v.br || m_pend) begin
        o = O_FL; m_pend = 0;
      end else if (hazard) begin
        o = O_LU; stalled = 1;
      end else begin
        o = O_NRM;
      end
    end
    if (stalled && m_stalls < (1 << CW) - 1) m_stalls++;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_PERF_EN
    return 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of inputs, compare at the falling edge, then let the edge happen.
  task automatic step(input in_t v, input string name, output logic [6:0] got, output logic [6:0] mexp);
    @(posedge clk); #1;
    rst                = v.rst;
    bus.IFID_RsAddr_i  = v.rs;
    bus.IFID_RtAddr_i  = v.rt;
    bus.IFID_UsesRt_i  = v.uses_rt;
    bus.IDEX_MemRead_i = v.memread;
    bus.IDEX_RtAddr_i  = v.idex_rt;
    bus.EXMEM_MemReq_i = v.memreq;
    bus.dmem_ready_i   = v.ready;
    bus.branch_taken_i = v.br;
    @(negedge clk);
    got = {bus.PC_Write_o, bus.IFID_Write_o, bus.IFID_Flush_o, bus.IDEX_Bubble_o,
           bus.Stage_Hold_o, bus.MEMWB_Bubble_o, bus.mem_err_o};
    chk({name, "_cnt"}, 32'(bus.stall_cnt_o), exp_cnt());
    model(v, mexp);
  endtask

  vec_t tbl[28];

  initial begin
    logic [6:0] got, mexp;
    in_t v;
    bus.IFID_RsAddr_i = '0; bus.IFID_RtAddr_i = '0; bus.IFID_UsesRt_i = 1'b0;
    bus.IDEX_MemRead_i = 1'b0; bus.IDEX_RtAddr_i = '0; bus.EXMEM_MemReq_i = 1'b0;
    bus.dmem_ready_i = 1'b0; bus.branch_taken_i = 1'b0;

    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0), O_RST};
    tbl[1]  = '{mk(1,2,0,0,1,2,0,0,0), O_LU};   // lw $2 then use $2
    tbl[2]  = '{mk(1,2,0,0,0,0,0,0,0), O_NRM};
    tbl[3]  = '{mk(1,0,0,0,1,0,0,0,0), O_NRM};  // $0 never hazards
    tbl[4]  = '{mk(1,1,3,0,1,3,0,0,0), O_NRM};  // rt match but rt not read
    tbl[5]  = '{mk(1,1,3,1,1,3,0,0,0), O_LU};
    tbl[6]  = '{mk(1,0,0,0,0,0,1,1,0), O_NRM};  // zero-wait memory
    tbl[7]  = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[8]  = '{mk(1,0,0,0,0,0,1,0,1), O_FRZ};  // branch during freeze
    tbl[9]  = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[10] = '{mk(1,0,0,0,0,0,1,1,0), O_FL};   // deferred flush on exit
    tbl[11] = '{mk(1,0,0,0,0,0,0,0,0), O_NRM};
    tbl[12] = '{mk(1,4,0,0,1,4,0,0,1), O_FL};   // branch beats load-use
    tbl[13] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[14] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[15] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[16] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[17] = '{mk(1,0,0,0,0,0,0,1,0), O_ERR};  // timeout is sticky
    tbl[18] = '{mk(1,0,0,0,0,0,1,1,0), O_ERR};
    tbl[19] = '{mk(0,0,0,0,0,0,0,0,0), O_RST};
    tbl[20] = '{mk(1,0,0,0,0,0,0,0,0), O_NRM};
    tbl[21] = '{mk(1,0,0,0,0,0,1,0,1), O_FRZ};
    tbl[22] = '{mk(0,0,0,0,0,0,1,0,0), O_RST};  // reset drops pend and wait
    tbl[23] = '{mk(1,0,0,0,0,0,0,0,0), O_NRM};
    tbl[24] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[25] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[26] = '{mk(1,0,0,0,0,0,1,0,0), O_FRZ};
    tbl[27] = '{mk(1,0,0,0,0,0,0,0,0), O_NRM};

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].in, $sformatf("vec%0d", i), got, mexp);
      chk($sformatf("vec%0d", i), 32'(got), 32'(tbl[i].exp));
    end

    // 20 load-use stalls saturate a 4-bit counter
    step(mk(0,0,0,0,0,0,0,0,0), "sat_rst", got, mexp);
    for (int i = 0; i < 20; i++) begin
      step(mk(1,5,0,0,1,5,0,0,0), "sat", got, mexp);
      chk("sat_flags", 32'(got), 32'(O_LU));
    end
    step(mk(1,0,0,0,0,0,0,0,0), "sat_end", got, mexp);
`ifdef STALL_PERF_EN
    chk("sat_value", 32'(bus.stall_cnt_o), 32'd15);
`else
    chk("sat_value", 32'(bus.stall_cnt_o), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 24) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 3) == 0));
      step(v, $sformatf("rnd%0d", i), got, mexp);
      chk($sformatf("rnd%0d", i), 32'(got), 32'(mexp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
